spi_slave_regs: RTL and testbench
=================================

# spi_slave_regs

SPI target that sits directly downstream of the DPI-driven SPI master, consuming its `spi_clk`/`spi_mosi`/`spi_cs` outputs and returning `spi_miso`. It oversamples the SPI pins on `sys_clk` and decodes a one-byte command followed by data bytes. It gives the master read/write access to an internal byte register file and reports every completed write to user logic as a single-cycle strobe.

## Interface
- `DEPTH`, 16: register-file size in bytes; power of two, 2..128; `ADDR_W = $clog2(DEPTH)`
- `RESET_VAL`, 8'h00: reset value of every register byte
- `sys_clk` input 1: system clock; all logic is on its rising edge
- `sys_rst_n` input 1: reset, asynchronous assert, active-low
- `spi_clk_i` input 1: SPI clock from master, asynchronous to `sys_clk`, idles high
- `spi_cs_i` input 1: chip select, active-low
- `spi_mosi_i` input 1: master-out data
- `spi_miso_o` output 1: slave-out data, always driven with no tristate
- `wr_stb_o` output 1: one-cycle pulse per committed write
- `wr_addr_o` output ADDR_W: address of the committed write
- `wr_data_o` output 8: data of the committed write
- `busy_o` output 1: high while a transaction is active (synchronized CS low)

## Operation
- SPI mode 3 (CPOL=1, CPHA=1), MSB first, 8-bit bytes.
- Slave samples MOSI on SCK rising edges and updates MISO on SCK falling edges.
- Byte 0 is the command: bit7 = 1 for write, 0 for read; bits[ADDR_W-1:0] = start address; the remaining address bits are ignored.
- Bytes 1..N are data.
- Write:
  - each completed data byte is stored at the current address;
  - `wr_stb_o` pulses with that address and data.
- Read:
  - when the 8th rising edge of the command byte (or of a data byte) is detected, register[current address] is loaded into the tx shifter;
  - its MSB appears on MISO after the following falling edge;
  - MOSI data bytes during a read are ignored.
- MISO is 0 in these cases:
  - during the command byte;
  - while CS is high;
  - during write transactions.
- State machine, `IDLE -> CMD -> DATA`:
  - `IDLE -> CMD`: synchronized CS falls.
  - `CMD -> DATA`: 8th sampled bit.
  - `DATA -> DATA`: every 8 bits.
  - any state `-> IDLE`: synchronized CS rises.
- Address handling:
  - the address wraps from DEPTH-1 to 0;
  - the bit counter is 3 bits and wraps every byte.
- CS rises mid-byte: the partial byte is discarded, nothing is written or strobed, and the slave returns to IDLE with the bit counter cleared.
- CS rise and SCK rise detected in the same cycle: CS wins and the edge is ignored.
- Reset (asynchronous, at any time, including mid-transaction): state IDLE; every output low; registers = RESET_VAL; synchronizers reset to idle levels (SCK=1, CS=1, MOSI=0).

## Timing
- All three SPI inputs pass through a 2-FF synchronizer, followed by one edge-detect register.
- Edge detection occurs 3 `sys_clk` cycles after a pin change.
- SCK high and SCK low phases must each be at least 4 `sys_clk` periods.
- CS setup to the first SCK falling edge must be at least 4 periods.
- MISO becomes valid ≤ 4 `sys_clk` cycles after the SCK falling edge at the pin.
- Register-file write and `wr_stb_o` assertion occur 1 cycle after the 8th data rising edge is detected.
- `wr_addr_o`/`wr_data_o` hold their values until the next strobe.
- `busy_o` follows synchronized CS (3-cycle latency).

## Configuration
- `SPI_SLV_AUTOINC_EN` defined: the current address increments (mod DEPTH) after every data byte.
- Undefined: the address stays at the command's start address for the whole transaction, so bursts repeatedly write or read the same register.

## Structure
- Package `spi_slave_pkg` holds:
  - the state enum `spi_slv_state_e`;
  - the constants `SPI_CMD_WR_BIT = 7` and `SPI_BYTE_W = 8`;
  - the idle levels of the synchronizers.
- Sub-module `spi_sync`: 2-FF synchronizer with a reset-value parameter, instantiated three times.
- The register file is a plain flop array in the top module.

## Test plan
- Reset: assert `sys_rst_n`=0 -> all outputs 0, `busy_o`=0, all registers 0x00 (verified by a read burst).
- Write 0x81,0xA5 -> `wr_stb_o` one pulse with addr 1 and data 0xA5; reg1=0xA5.
- Read 0x01 plus one dummy byte after reg1=0xA5 -> MISO shifts 0xA5; MISO=0 during the command byte.
- Burst write 0x8F (DEPTH=16),0x11,0x22 with AUTOINC -> reg15=0x11, reg0=0x22 (wrap). Without the macro -> reg15=0x22 and reg0 unchanged.
- CS raised after 5 bits of data byte 0xFF following command 0x82 -> no strobe, reg2 unchanged; the next full write 0x82,0x3C succeeds.
- `sys_rst_n` pulsed low mid-read -> MISO=0 and the state is IDLE immediately; a subsequent transaction decodes correctly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_slave_pkg;
  localparam int   SPI_CMD_WR_BIT = 7;
  localparam int   SPI_BYTE_W     = 8;
  localparam logic SCK_IDLE       = 1'b1;
  localparam logic CS_IDLE        = 1'b1;
  localparam logic MOSI_IDLE      = 1'b0;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} spi_slv_state_e;
endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer; RST_VAL is the level the pin sits at while idle.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-3 slave giving byte read/write access to a small register file.
// Define SPI_SLV_AUTOINC_EN to step the address after every data byte.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00,
  localparam int         ADDR_W    = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              wr_stb_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o
);
  logic sck_s, cs_s, mosi_s, sck_q, cs_q;

  spi_sync #(.RST_VAL(SCK_IDLE))  u_sync_sck  (.sys_clk, .sys_rst_n, .d(spi_clk_i),  .q(sck_s));
  spi_sync #(.RST_VAL(CS_IDLE))   u_sync_cs   (.sys_clk, .sys_rst_n, .d(spi_cs_i),   .q(cs_s));
  spi_sync #(.RST_VAL(MOSI_IDLE)) u_sync_mosi (.sys_clk, .sys_rst_n, .d(spi_mosi_i), .q(mosi_s));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sck_q <= SCK_IDLE;
      cs_q  <= CS_IDLE;
    end else begin
      sck_q <= sck_s;
      cs_q  <= cs_s;
    end
  end

  assign busy_o = ~cs_q;

  spi_slv_state_e          state_q, state_d;
  logic [2:0]              bit_cnt;
  logic [SPI_BYTE_W-1:0]   rx_sr, tx_sr, rx_byte;
  logic [ADDR_W-1:0]       addr_q, nxt_addr, cmd_addr;
  logic                    is_wr;
  logic [SPI_BYTE_W-1:0]   regs [DEPTH];
  logic                    sck_rise, sck_fall, byte_done;

  assign sck_rise  = sck_s & ~sck_q;
  assign sck_fall  = ~sck_s & sck_q;
  assign rx_byte   = {rx_sr[SPI_BYTE_W-2:0], mosi_s};
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  // CS high masks any SCK edge seen in the same cycle.
  assign byte_done = sck_rise && !cs_s && (state_q != ST_IDLE) && (bit_cnt == 3'd7);

`ifdef SPI_SLV_AUTOINC_EN
  assign nxt_addr = addr_q + 1'b1;
`else
  assign nxt_addr = addr_q;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!cs_s)     state_d = ST_CMD;
      ST_CMD:  if (byte_done) state_d = ST_DATA;
      ST_DATA: state_d = ST_DATA;
      default: state_d = ST_IDLE;
    endcase
    if (cs_s) state_d = ST_IDLE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      addr_q     <= '0;
      is_wr      <= 1'b0;
      spi_miso_o <= 1'b0;
      wr_stb_o   <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_stb_o <= 1'b0;
      if (cs_s) begin
        // Partial bytes are simply dropped; only the counter needs clearing.
        bit_cnt    <= '0;
        spi_miso_o <= 1'b0;
      end else if (state_q != ST_IDLE) begin
        if (sck_rise) begin
          rx_sr   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (state_q == ST_CMD) begin
              addr_q <= cmd_addr;
              is_wr  <= rx_byte[SPI_CMD_WR_BIT];
              tx_sr  <= regs[cmd_addr];
            end else if (is_wr) begin
              regs[addr_q] <= rx_byte;
              wr_stb_o     <= 1'b1;
              wr_addr_o    <= addr_q;
              wr_data_o    <= rx_byte;
              addr_q       <= nxt_addr;
            end else begin
              tx_sr  <= regs[nxt_addr];
              addr_q <= nxt_addr;
            end
          end
        end else if (sck_fall) begin
          if (state_q == ST_DATA && !is_wr) begin
            spi_miso_o <= tx_sr[SPI_BYTE_W-1];
            tx_sr      <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
          end else begin
            spi_miso_o <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: random mode-3 transactions against a register-array model.
module tb_spi_slave_regs;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int HALF  = 6;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          spi_clk = 1'b1;
  logic          spi_cs = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso_o, wr_stb_o, busy_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;

  spi_slave_regs #(.DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .spi_clk_i  (spi_clk),
    .spi_cs_i   (spi_cs),
    .spi_mosi_i (spi_mosi),
    .spi_miso_o (spi_miso_o),
    .wr_stb_o   (wr_stb_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0]    mdl [DEPTH];
  logic [AW-1:0] exp_wa [$];
  logic [7:0]    exp_wd [$];
  logic [7:0]    exp_miso [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_clk  = 1'b0;
      spi_mosi = b[7-i];
      wait_clk(HALF);
      spi_clk  = 1'b1;
      wait_clk(HALF);
    end
  endtask

  // One transaction: command, n data bytes, optional trailing partial byte.
  task automatic xfer(input logic [7:0] cmd, input int n, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2, input int abort_bits);
    logic [7:0]    d [3];
    logic [AW-1:0] a;
    d[0] = b0; d[1] = b1; d[2] = b2;
    a = cmd[AW-1:0];
    spi_cs = 1'b0;
    wait_clk(HALF);
    exp_miso.push_back(8'h00);
    spi_bits(cmd, 8);
    chk("busy_active", busy_o, 1);
    for (int i = 0; i < n; i++) begin
      if (cmd[7]) begin
        exp_wa.push_back(a);
        exp_wd.push_back(d[i]);
        mdl[a] = d[i];
        exp_miso.push_back(8'h00);
      end else begin
        exp_miso.push_back(mdl[a]);
      end
      spi_bits(d[i], 8);
`ifdef SPI_SLV_AUTOINC_EN
      a = a + 1'b1;
`endif
    end
    if (abort_bits > 0) spi_bits(8'hFF, abort_bits);
    wait_clk(HALF);
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(8);
  endtask

  // Write-strobe monitor.
  always @(negedge sys_clk) begin
    if (sys_rst_n && wr_stb_o) begin
      if (exp_wa.size() == 0) chk("wr_stb_unexpected", 1, 0);
      else begin
        chk("wr_addr", wr_addr_o, exp_wa.pop_front());
        chk("wr_data", wr_data_o, exp_wd.pop_front());
      end
    end
  end

  // MISO monitor: assembles whole bytes as the master would see them.
  int         nb = 0;
  logic [7:0] sh = '0;
  always @(posedge spi_clk or posedge spi_cs) begin
    if (spi_cs) nb = 0;
    else begin
      sh = {sh[6:0], spi_miso_o};
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (exp_miso.size() == 0) chk("miso_unexpected", 1, 0);
        else chk("miso_byte", sh, exp_miso.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, x0, x1, x2;
    int         n, ab;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    wait_clk(5);
    chk("rst_miso",    spi_miso_o, 0);
    chk("rst_wr_stb",  wr_stb_o,   0);
    chk("rst_busy",    busy_o,     0);
    chk("rst_wr_addr", wr_addr_o,  0);
    chk("rst_wr_data", wr_data_o,  0);
    sys_rst_n = 1'b1;
    wait_clk(5);

    for (int i = 0; i < DEPTH; i++) xfer(8'(i), 1, 8'h00, 8'h00, 8'h00, 0);

    xfer(8'h81, 1, 8'hA5, 8'h00, 8'h00, 0);
    xfer(8'h01, 1, 8'h00, 8'h00, 8'h00, 0);

    xfer(8'h8F, 2, 8'h11, 8'h22, 8'h00, 0);
    xfer(8'h0F, 1, 8'h00, 8'h00, 8'h00, 0);
    xfer(8'h00, 1, 8'h00, 8'h00, 8'h00, 0);

    xfer(8'h82, 0, 8'h00, 8'h00, 8'h00, 5);
    xfer(8'h02, 1, 8'h00, 8'h00, 8'h00, 0);
    xfer(8'h82, 1, 8'h3C, 8'h00, 8'h00, 0);
    xfer(8'h02, 1, 8'h00, 8'h00, 8'h00, 0);

    // Reset in the middle of a read data byte.
    spi_cs = 1'b0;
    wait_clk(HALF);
    exp_miso.push_back(8'h00);
    spi_bits(8'h01, 8);
    spi_bits(8'h00, 3);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_miso", spi_miso_o, 0);
    chk("midrst_busy", busy_o, 0);
    spi_cs = 1'b1;
    wait_clk(4);
    sys_rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    wait_clk(4);
    xfer(8'h01, 1, 8'h00, 8'h00, 8'h00, 0);
    xfer(8'h83, 1, 8'h5A, 8'h00, 8'h00, 0);
    xfer(8'h03, 1, 8'h00, 8'h00, 8'h00, 0);

    for (int k = 0; k < 30; k++) begin
      c  = 8'($urandom);
      n  = $urandom_range(1, 3);
      x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      xfer(c, n, x0, x1, x2, ab);
    end

    wait_clk(20);
    chk("wr_queue_drained",   exp_wa.size(),   0);
    chk("miso_queue_drained", exp_miso.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
